sqrt_pwl_eval: RTL and testbench

- Pipelined square-root evaluator for the Box-Muller datapath; computes f = sqrt(e) for the e = -2ln(u1) stage output.
- Range-reduces e and drives the address port of two 64-entry coefficient ROMs. The ROMs are combinational, 64x32, with c1 in [31:20] and c0 in [19:0].
  - Even table: sqrt(x), x in [1,2).
  - Odd table: sqrt(2x), x in [1,2).
- Consumes the returned coefficients and evaluates y = c0 + c1*xb, then restores the exponent.
- Valid/ready stream on both sides.

---
 rtl/sqrt_pwl_eval.sv | 160 ++++++++++++++++
 tb/tb_sqrt_pwl_eval.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_pwl_eval.sv
// sqrt_pwl_eval: four-stage piecewise-linear square root for the Box-Muller
// e = -2ln(u1) -> f = sqrt(e) stage. Range-reduces e to [1,2) (even exponent)
// or sqrt(2x) (odd exponent), looks up {c1,c0} in external ROMs, evaluates
// c0 + c1*xb and restores the halved exponent.
module sqrt_pwl_eval #(
  parameter int unsigned E_W = 31,
  parameter int unsigned F_W = 20,
  parameter int unsigned LAT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [E_W-1:0] e_in,
  output logic [5:0]     even_addr,
  input  logic [31:0]    even_data,
  output logic [5:0]     odd_addr,
  input  logic [31:0]    odd_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [F_W-1:0] f_out,
  output logic           f_zero
);

  localparam int unsigned A_W  = 6;
  localparam int unsigned XB_W = 17;
  localparam int unsigned C1_W = 12;
  localparam int unsigned C0_W = 20;
  localparam int unsigned K_W  = 5;
  localparam int unsigned N_W  = 23;

  logic                  adv;
  logic [LAT-1:0]        vld;

  logic [4:0]            lead_c;
  logic signed [5:0]     ex_c;
  logic [4:0]            sh_c;
  logic [N_W-1:0]        nmid_c;
  logic                  zero_c;

  logic [A_W-1:0]        addr1;
  logic [XB_W-1:0]       xb1;
  logic signed [K_W-1:0] k1;
  logic                  par1;
  logic                  z1;

  logic [31:0]           sel_c;
  logic [C1_W-1:0]       c1_2;
  logic [C0_W-1:0]       c0_2;
  logic [XB_W-1:0]       xb2;
  logic signed [K_W-1:0] k2;
  logic                  z2;

  logic [28:0]           prod_c;
  logic [F_W-1:0]        y_c;
  logic [F_W-1:0]        y3;
  logic signed [K_W-1:0] k3;
  logic                  z3;

  logic [F_W-1:0]        fy_c;

  // The whole pipe advances unless the output register is stalled.
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld[LAT-1];
  assign even_addr = addr1;
  assign odd_addr  = addr1;

  // Leading-one position of e_in (highest set bit wins).
  always_comb begin
    lead_c = '0;
    for (int i = 0; i < int'(E_W); i++) begin
      if (e_in[i]) lead_c = 5'(i);
    end
  end

  // Range reduction: exponent, normalising shift and the norm[29:7] window.
  always_comb begin
    zero_c = (e_in == '0);
    ex_c   = $signed(6'(lead_c)) - 6'sd26;
    sh_c   = 5'(5'd30 - lead_c);
    nmid_c = N_W'((e_in << sh_c) >> 7);
  end

  // S1: register segment address, offset, half exponent and parity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld   <= '0;
      addr1 <= '0;
      xb1   <= '0;
      k1    <= '0;
      par1  <= 1'b0;
      z1    <= 1'b0;
    end else if (adv) begin
      vld   <= {vld[LAT-2:0], in_valid};
      addr1 <= zero_c ? '0 : nmid_c[22:17];
      xb1   <= zero_c ? '0 : nmid_c[16:0];
      k1    <= zero_c ? '0 : K_W'(ex_c >>> 1);
      par1  <= ex_c[0];
      z1    <= zero_c;
    end
  end

  // Odd exponents use the sqrt(2x) table.
  assign sel_c = par1 ? odd_data : even_data;

  // S2: capture the selected coefficients.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_2 <= '0;
      c0_2 <= '0;
      xb2  <= '0;
      k2   <= '0;
      z2   <= 1'b0;
    end else if (adv) begin
      c1_2 <= sel_c[31:20];
      c0_2 <= sel_c[19:0];
      xb2  <= xb1;
      k2   <= k1;
      z2   <= z1;
    end
  end

  // Linear term: product LSB is 2^-32, shift by 15 aligns it to c0 (2^-17).
  always_comb begin
    prod_c = 29'(c1_2) * 29'(xb2);
    y_c    = c0_2 + F_W'(prod_c >> 15);
  end

  // S3: register the mantissa result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y3 <= '0;
      k3 <= '0;
      z3 <= 1'b0;
    end else if (adv) begin
      y3 <= y_c;
      k3 <= k2;
      z3 <= z2;
    end
  end

  // Exponent restore: left shift for k >= 0 (k <= 2), truncating right shift otherwise.
  always_comb begin
    if (k3[K_W-1]) fy_c = y3 >> K_W'(-k3);
    else           fy_c = y3 << k3[1:0];
  end

  // S4: output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_out  <= '0;
      f_zero <= 1'b0;
    end else if (adv) begin
      f_out  <= z3 ? '0 : fy_c;
      f_zero <= z3;
    end
  end

endmodule

// File: tb/tb_sqrt_pwl_eval.sv
// Self-checking bench for sqrt_pwl_eval: bench-owned coefficient ROMs, an
// arithmetic reference model, directed corner cases, random streams with and
// without output back-pressure, and a mid-flight reset.
module tb_sqrt_pwl_eval;

  typedef struct {
    logic [30:0] e;
    logic [19:0] f;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] e_in;
  logic [5:0]  even_addr;
  logic [31:0] even_data;
  logic [5:0]  odd_addr;
  logic [31:0] odd_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] f_out;
  logic        f_zero;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [31:0] even_rom [64];
  logic [31:0] odd_rom  [64];
  exp_t        exp_q [$];

  bit          stalled_prev = 1'b0;
  logic [19:0] hold_f;
  logic        hold_z;
  logic [5:0]  hold_ea;
  logic [5:0]  hold_oa;

  sqrt_pwl_eval dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e_in      (e_in),
    .even_addr (even_addr),
    .even_data (even_data),
    .odd_addr  (odd_addr),
    .odd_data  (odd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .f_zero    (f_zero)
  );

  always #5 clk = ~clk;

  // Combinational ROMs.
  assign even_data = even_rom[even_addr];
  assign odd_data  = odd_rom[odd_addr];

  function automatic real fx(input bit odd, input real x);
    return odd ? $sqrt(2.0 * x) : $sqrt(x);
  endfunction

  // Segment coefficients: quantised secant slope, c0 centred on the residual.
  function automatic logic [31:0] coef(input bit odd, input int i);
    real h, x0, t, d, dmin, dmax, slope, c0r;
    int  c1q, c0q;
    h     = 1.0 / 64.0;
    x0    = 1.0 + i * h;
    slope = (fx(odd, x0 + h) - fx(odd, x0)) / h;
    c1q   = $rtoi(slope * 512.0 + 0.5);
    dmin  = 1.0e9;
    dmax  = -1.0e9;
    for (int j = 0; j <= 64; j++) begin
      t = j * h / 64.0;
      d = fx(odd, x0 + t) - c1q * t / 512.0;
      if (d < dmin) dmin = d;
      if (d > dmax) dmax = d;
    end
    c0r = (dmin + dmax) / 2.0 + 0.5 / 131072.0;
    c0q = $rtoi(c0r * 131072.0 + 0.5);
    return {12'(c1q), 20'(c0q)};
  endfunction

  // Reference model: plain integer arithmetic on the value of e.
  function automatic exp_t model(input logic [30:0] e);
    exp_t        r;
    int          p, ex, k, addr, xb, c1, c0, y;
    longint      norm;
    logic [31:0] w;
    r.e = e;
    r.z = (e == 0);
    r.f = '0;
    if (e != 0) begin
      p = 30;
      while (e[p] == 1'b0) p--;
      ex   = p - 26;
      k    = (ex >= 0) ? ex / 2 : -((1 - ex) / 2);
      norm = longint'(e) * (longint'(1) << (30 - p));
      addr = int'((norm / 64'd16777216) % 64);
      xb   = int'((norm / 64'd128) % 131072);
      w    = (ex % 2 != 0) ? odd_rom[addr] : even_rom[addr];
      c1   = int'(w[31:20]);
      c0   = int'(w[19:0]);
      y    = c0 + (c1 * xb) / 32768;
      if (k >= 0) r.f = 20'(y * (2 ** k));
      else        r.f = 20'(y / (2 ** (-k)));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, check, track handshakes, advance.
  task automatic cycle(input bit iv, input logic [30:0] e, input bit ordy, output bit acc);
    exp_t m;
    real  fr, sr;
    in_valid  = iv;
    e_in      = e;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (stalled_prev) begin
      chk("hold_f", 32'(f_out), 32'(hold_f));
      chk("hold_zero", 32'(f_zero), 32'(hold_z));
      chk("hold_even_addr", 32'(even_addr), 32'(hold_ea));
      chk("hold_odd_addr", 32'(odd_addr), 32'(hold_oa));
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL spurious_out: observed out_valid=1 f_out=%0h expected no pending sample", f_out);
      end
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        pops++;
        chk("f_out", 32'(f_out), 32'(m.f));
        chk("f_zero", 32'(f_zero), 32'(m.z));
        if (m.e >= 31'h4000000) begin
          fr = real'(f_out) / 131072.0;
          sr = $sqrt(real'(m.e) / 67108864.0);
          checks++;
          assert ((fr - sr <= sr / 32768.0) && (sr - fr <= sr / 32768.0))
          else begin
            errors++;
            $error("FAIL tol e=%0h: observed %f expected %f", m.e, fr, sr);
          end
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(e));
    stalled_prev = out_valid && !out_ready;
    hold_f  = f_out;
    hold_z  = f_zero;
    hold_ea = even_addr;
    hold_oa = odd_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single sample on an empty pipe: latency and absolute result.
  task automatic directed(input logic [30:0] e, input logic [19:0] ef, input logic ez, input string tag);
    bit acc;
    int lat;
    cycle(1'b1, e, 1'b1, acc);
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle(1'b0, '0, 1'b1, acc);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_f"}, 32'(f_out), 32'(ef));
    chk({tag, "_zero"}, 32'(f_zero), 32'(ez));
    cycle(1'b0, '0, 1'b1, acc);
  endtask

  initial begin
    bit          acc;
    int          sent, guard, p0;
    logic [30:0] e;
    logic [19:0] c0_even0, c0_odd0;

    for (int i = 0; i < 64; i++) begin
      even_rom[i] = coef(1'b0, i);
      odd_rom[i]  = coef(1'b1, i);
    end
    c0_even0 = even_rom[0][19:0];
    c0_odd0  = odd_rom[0][19:0];

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e_in      = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_f_out", 32'(f_out), 32'd0);
    chk("rst_f_zero", 32'(f_zero), 32'd0);
    chk("rst_even_addr", 32'(even_addr), 32'd0);
    chk("rst_odd_addr", 32'(odd_addr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed corners.
    directed(31'h08000000, c0_odd0, 1'b0, "two");
    directed(31'h20000000, 20'(c0_odd0 * 2), 1'b0, "eight");
    directed(31'h04000000, c0_even0, 1'b0, "one");
    directed(31'h00000001, c0_even0 >> 13, 1'b0, "lsb");
    directed(31'h00000000, 20'h0, 1'b1, "zero");

    // Back-to-back random stream, e in [1,32).
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      e = 31'($urandom_range(32'h7FFFFFFF, 32'h04000000));
      cycle(1'b1, e, 1'b1, acc);
      chk("b2b_accept", 32'(acc), 32'd1);
    end
    repeat (4) cycle(1'b0, '0, 1'b1, acc);
    chk("b2b_outputs", 32'(pops - p0), 32'd16);
    chk("b2b_queue", 32'(exp_q.size()), 32'd0);

    // Random stream with random back-pressure over the full input range.
    sent  = 0;
    guard = 0;
    while (sent < 32 && guard < 2000) begin
      case ($urandom % 4)
        0:       e = '0;
        1:       e = 31'($urandom) >> ($urandom % 31);
        default: e = 31'($urandom_range(32'h7FFFFFFF, 32'h04000000));
      endcase
      cycle(($urandom % 4) != 0, e, 1'($urandom % 2), acc);
      if (acc) sent++;
      guard++;
    end
    chk("stall_sent", 32'(sent), 32'd32);
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
      cycle(1'b0, '0, 1'($urandom % 2), acc);
      guard++;
    end
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      e = 31'($urandom_range(32'h7FFFFFFF, 32'h04000000));
      cycle(1'b1, e, 1'b1, acc);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_f_out", 32'(f_out), 32'd0);
    chk("mid_rst_f_zero", 32'(f_zero), 32'd0);
    chk("mid_rst_even_addr", 32'(even_addr), 32'd0);
    chk("mid_rst_odd_addr", 32'(odd_addr), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    stalled_prev = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    p0 = pops;
    repeat (6) cycle(1'b0, '0, 1'b1, acc);
    chk("post_rst_no_output", 32'(pops - p0), 32'd0);
    directed(31'h04000000, c0_even0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
